// File: rtl/parking_gate_sequencer.sv
// Parking lane front end: beam synchronizers/debouncers, passage-order FSM, occupancy count and sign.
// Optional passage timeout is compiled in with `define GATE_TIMEOUT_EN.
module parking_gate_sequencer #(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int CAPACITY         = 8,
    parameter int TIMEOUT_CYCLES   = 250000000,
    parameter int SIGN_HOLD_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       reject_pulse,
    output logic [3:0] occupied,
    output logic       full,
    output logic       empty,
    output logic [2:0] traffic_sign
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (SIGN_HOLD_CYCLES > 1) ? $clog2(SIGN_HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(SIGN_HOLD_CYCLES - 1);
    localparam logic [3:0]    CAP       = 4'(CAPACITY);
    localparam logic [2:0]    SIGN_IDLE = 3'b001;
    localparam logic [2:0]    SIGN_GO   = 3'b010;
    localparam logic [2:0]    SIGN_STOP = 3'b100;

    typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLEAR} state_t;

    function automatic logic [2:0] rest_sign(input logic is_full);
        if (is_full) begin
            rest_sign = SIGN_STOP;
        end else begin
            rest_sign = SIGN_IDLE;
        end
    endfunction

    logic          a_meta_r, a_sync_r, b_meta_r, b_sync_r;
    logic          da_r, db_r;
    logic [DW-1:0] a_cnt_r, b_cnt_r;
    logic [1:0]    lv_s;
    state_t        state_r, state_next_s;
    logic          entry_done_s, exit_done_s, timeout_s, to_hit_s;
    logic          entry_ok_s, exit_ok_s, reject_s;
    logic [3:0]    occ_next_s;
    logic          entry_r, exit_r, reject_r, full_r, empty_r;
    logic [3:0]    occ_r;
    logic [2:0]    sign_r;
    logic [HW-1:0] hold_r;

    assign lv_s = {da_r, db_r};

    // Two-stage synchronizers for the asynchronous beam inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_meta_r <= 1'b0;
            a_sync_r <= 1'b0;
            b_meta_r <= 1'b0;
            b_sync_r <= 1'b0;
        end else begin
            a_meta_r <= sensor_a;
            a_sync_r <= a_meta_r;
            b_meta_r <= sensor_b;
            b_sync_r <= b_meta_r;
        end
    end

    // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            da_r    <= 1'b0;
            db_r    <= 1'b0;
            a_cnt_r <= {DW{1'b0}};
            b_cnt_r <= {DW{1'b0}};
        end else begin
            if (a_sync_r == da_r) begin
                a_cnt_r <= {DW{1'b0}};
            end else if (a_cnt_r == DEB_LAST) begin
                da_r    <= a_sync_r;
                a_cnt_r <= {DW{1'b0}};
            end else begin
                a_cnt_r <= a_cnt_r + DW'(1);
            end
            if (b_sync_r == db_r) begin
                b_cnt_r <= {DW{1'b0}};
            end else if (b_cnt_r == DEB_LAST) begin
                db_r    <= b_sync_r;
                b_cnt_r <= {DW{1'b0}};
            end else begin
                b_cnt_r <= b_cnt_r + DW'(1);
            end
        end
    end

`ifdef GATE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_r;
    logic          to_active_s;

    assign to_active_s = (state_r != IDLE) && (state_r != WAIT_CLEAR);
    assign to_hit_s    = to_active_s && (to_cnt_r == TO_LAST);

    // Age of the current passage state; restarts on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r <= {TW{1'b0}};
        end else if ((state_next_s != state_r) || !to_active_s) begin
            to_cnt_r <= {TW{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Passage FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Passage decode; any two-beam change at once abandons the passage via WAIT_CLEAR
    always_comb begin
        state_next_s = state_r;
        entry_done_s = 1'b0;
        exit_done_s  = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: case (lv_s)
                2'b10:   state_next_s = IN1;
                2'b01:   state_next_s = OUT1;
                2'b11:   state_next_s = WAIT_CLEAR;
                default: state_next_s = IDLE;
            endcase
            IN1: case (lv_s)
                2'b11:   state_next_s = IN2;
                2'b00:   state_next_s = IDLE;
                2'b01:   state_next_s = WAIT_CLEAR;
                default: state_next_s = IN1;
            endcase
            IN2: case (lv_s)
                2'b01:   state_next_s = IN3;
                2'b10:   state_next_s = IN1;
                2'b00:   state_next_s = WAIT_CLEAR;
                default: state_next_s = IN2;
            endcase
            IN3: case (lv_s)
                2'b00: begin
                    state_next_s = IDLE;
                    entry_done_s = 1'b1;
                end
                2'b11:   state_next_s = IN2;
                2'b10:   state_next_s = WAIT_CLEAR;
                default: state_next_s = IN3;
            endcase
            OUT1: case (lv_s)
                2'b11:   state_next_s = OUT2;
                2'b00:   state_next_s = IDLE;
                2'b10:   state_next_s = WAIT_CLEAR;
                default: state_next_s = OUT1;
            endcase
            OUT2: case (lv_s)
                2'b10:   state_next_s = OUT3;
                2'b01:   state_next_s = OUT1;
                2'b00:   state_next_s = WAIT_CLEAR;
                default: state_next_s = OUT2;
            endcase
            OUT3: case (lv_s)
                2'b00: begin
                    state_next_s = IDLE;
                    exit_done_s  = 1'b1;
                end
                2'b11:   state_next_s = OUT2;
                2'b01:   state_next_s = WAIT_CLEAR;
                default: state_next_s = OUT3;
            endcase
            WAIT_CLEAR: begin
                if (lv_s == 2'b00) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_CLEAR;
                end
            end
            default: state_next_s = IDLE;
        endcase
        if (to_hit_s && (state_next_s == state_r)) begin
            state_next_s = WAIT_CLEAR;
            timeout_s    = 1'b1;
        end else begin
            timeout_s    = 1'b0;
        end
    end

    // Accept/reject decision; saturation comes from these checks, never from wrap logic
    always_comb begin
        entry_ok_s = 1'b0;
        exit_ok_s  = 1'b0;
        reject_s   = timeout_s;
        occ_next_s = occ_r;
        if (entry_done_s) begin
            if (occ_r < CAP) begin
                entry_ok_s = 1'b1;
                occ_next_s = occ_r + 4'd1;
            end else begin
                reject_s   = 1'b1;
            end
        end else if (exit_done_s) begin
            if (occ_r > 4'd0) begin
                exit_ok_s  = 1'b1;
                occ_next_s = occ_r - 4'd1;
            end else begin
                reject_s   = 1'b1;
            end
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Event pulses, occupancy flags and the held traffic sign
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_r  <= 1'b0;
            exit_r   <= 1'b0;
            reject_r <= 1'b0;
            occ_r    <= 4'd0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            sign_r   <= SIGN_IDLE;
            hold_r   <= {HW{1'b0}};
        end else begin
            entry_r  <= entry_ok_s;
            exit_r   <= exit_ok_s;
            reject_r <= reject_s;
            occ_r    <= occ_next_s;
            full_r   <= (occ_next_s == CAP);
            empty_r  <= (occ_next_s == 4'd0);
            if (entry_ok_s || exit_ok_s) begin
                hold_r <= HOLD_LOAD;
                sign_r <= SIGN_GO;
            end else if (reject_s) begin
                hold_r <= HOLD_LOAD;
                sign_r <= SIGN_STOP;
            end else if (hold_r != {HW{1'b0}}) begin
                hold_r <= hold_r - HW'(1);
            end else begin
                sign_r <= rest_sign(full_r);
            end
        end
    end

    assign entry_pulse  = entry_r;
    assign exit_pulse   = exit_r;
    assign reject_pulse = reject_r;
    assign occupied     = occ_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign traffic_sign = sign_r;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Bench for parking_gate_sequencer: directed scenarios plus random passages against a
// passage-level model (beam levels mapped onto a 4-position ring, net winding decides the event).
module tb_parking_gate_sequencer;
    localparam int DEB = 4, CAP = 2, TO = 64, HOLD = 8;

    logic       clk = 1'b0, reset_n = 1'b1, sensor_a = 1'b0, sensor_b = 1'b0;
    logic       entry_pulse, exit_pulse, reject_pulse, full, empty;
    logic [3:0] occupied;
    logic [2:0] traffic_sign;

    int n_vec = 0, n_bad = 0;
    int cnt_en = 0, cnt_ex = 0, cnt_rj = 0, cnt_multi = 0;
    int exp_en = 0, exp_ex = 0, exp_rj = 0, occ_m = 0;
    logic [1:0] cur_l = 2'b00;
    int  disp = 0;
    bit  void_p = 1'b0;

    parking_gate_sequencer #(.DEBOUNCE_CYCLES(DEB), .CAPACITY(CAP), .TIMEOUT_CYCLES(TO),
                             .SIGN_HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .reject_pulse(reject_pulse),
        .occupied(occupied), .full(full), .empty(empty), .traffic_sign(traffic_sign));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (entry_pulse)  cnt_en++;
            if (exit_pulse)   cnt_ex++;
            if (reject_pulse) cnt_rj++;
            if ((int'(entry_pulse) + int'(exit_pulse) + int'(reject_pulse)) > 1) cnt_multi++;
        end
    end

    function automatic int pos_of(input logic [1:0] l);
        case (l)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] lvl_of(input int p);
        case (((p % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_step(input logic [1:0] nl);
        if (nl != cur_l) begin
            if ((nl ^ cur_l) == 2'b11) void_p = 1'b1;
            else if (pos_of(nl) == (pos_of(cur_l) + 1) % 4) disp++;
            else disp--;
            cur_l = nl;
            if (nl == 2'b00) begin
                if (!void_p && disp == 4) begin
                    if (occ_m < CAP) begin occ_m++; exp_en++; end else exp_rj++;
                end else if (!void_p && disp == -4) begin
                    if (occ_m > 0) begin occ_m--; exp_ex++; end else exp_rj++;
                end
                disp = 0;
                void_p = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        occ_m = 0; cur_l = 2'b00; disp = 0; void_p = 1'b0;
    endtask

    task automatic drive_level(input logic [1:0] l, input int n);
        {sensor_a, sensor_b} = l;
        model_step(l);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sensor_a = 1'b0; sensor_b = 1'b0; reset_n = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic entry_passage();
        drive_level(2'b10, 10); drive_level(2'b11, 10); drive_level(2'b01, 10); drive_level(2'b00, 20);
    endtask

    task automatic test_reset();
        sensor_a = 1'b0; sensor_b = 1'b0; reset_n = 1'b0;
        model_clear();
        #1;
        n_vec++; if (occupied !== 4'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occupied); end
        n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", empty, full); end
        n_vec++; if (traffic_sign !== 3'b001) begin n_bad++; $display("FAIL reset_sign got %b want 001", traffic_sign); end
        n_vec++; if ({entry_pulse, exit_pulse, reject_pulse} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {entry_pulse, exit_pulse, reject_pulse}); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++; if (traffic_sign !== 3'b001 || occupied !== 4'd0) begin n_bad++; $display("FAIL post_reset_idle got sign=%b occ=%0d want 001/0", traffic_sign, occupied); end
    endtask

    task automatic test_clean_entry();
        logic [2:0] hist [0:39];
        int lat, ok8, b_en;
        b_en = cnt_en; lat = 0;
        drive_level(2'b10, 10); drive_level(2'b11, 10); drive_level(2'b01, 10);
        model_step(2'b00);
        {sensor_a, sensor_b} = 2'b00;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            hist[k] = traffic_sign;
            if (entry_pulse && lat == 0) lat = k;
        end
        n_vec++; if (lat != 2 + DEB + 1) begin n_bad++; $display("FAIL entry_latency got %0d want %0d", lat, 2 + DEB + 1); end
        n_vec++; if (cnt_en - b_en != 1) begin n_bad++; $display("FAIL entry_count got %0d want 1", cnt_en - b_en); end
        n_vec++; if (occupied !== 4'd1 || empty !== 1'b0) begin n_bad++; $display("FAIL entry_occ got %0d e=%b want 1 e=0", occupied, empty); end
        if (lat > 0 && lat + HOLD < 40) begin
            ok8 = 0;
            for (int k = lat; k < lat + HOLD; k++) if (hist[k] === 3'b010) ok8++;
            n_vec++; if (ok8 != HOLD) begin n_bad++; $display("FAIL go_hold got %0d cycles of 010 want %0d", ok8, HOLD); end
            n_vec++; if (hist[lat + HOLD] !== 3'b001) begin n_bad++; $display("FAIL go_revert got %b want 001", hist[lat + HOLD]); end
        end
    endtask

    task automatic test_fill_and_reject();
        int b_en, b_rj;
        b_en = cnt_en;
        entry_passage();
        n_vec++; if (cnt_en - b_en != 1 || occupied !== 4'd2) begin n_bad++; $display("FAIL second_entry got n=%0d occ=%0d want 1/2", cnt_en - b_en, occupied); end
        n_vec++; if (full !== 1'b1 || traffic_sign !== 3'b100) begin n_bad++; $display("FAIL full_sign got f=%b sign=%b want 1/100", full, traffic_sign); end
        b_en = cnt_en; b_rj = cnt_rj;
        drive_level(2'b10, 10); drive_level(2'b11, 10); drive_level(2'b01, 10); drive_level(2'b00, 8);
        n_vec++; if (traffic_sign !== 3'b100) begin n_bad++; $display("FAIL reject_sign got %b want 100", traffic_sign); end
        repeat (20) @(negedge clk);
        n_vec++; if (cnt_rj - b_rj != 1 || cnt_en - b_en != 0) begin n_bad++; $display("FAIL third_entry got rj=%0d en=%0d want 1/0", cnt_rj - b_rj, cnt_en - b_en); end
        n_vec++; if (occupied !== 4'd2) begin n_bad++; $display("FAIL full_occ got %0d want 2", occupied); end
    endtask

    task automatic test_exit_empty();
        int b_ex, b_rj;
        do_reset();
        b_ex = cnt_ex; b_rj = cnt_rj;
        drive_level(2'b01, 10); drive_level(2'b11, 10); drive_level(2'b10, 10); drive_level(2'b00, 20);
        n_vec++; if (cnt_rj - b_rj != 1 || cnt_ex - b_ex != 0) begin n_bad++; $display("FAIL empty_exit got rj=%0d ex=%0d want 1/0", cnt_rj - b_rj, cnt_ex - b_ex); end
        n_vec++; if (occupied !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL empty_occ got %0d e=%b want 0 e=1", occupied, empty); end
    endtask

    task automatic test_backout_glitch();
        int b_en, b_ex, b_rj;
        entry_passage();
        b_en = cnt_en; b_ex = cnt_ex; b_rj = cnt_rj;
        drive_level(2'b10, 10); drive_level(2'b11, 10); drive_level(2'b10, 10); drive_level(2'b00, 20);
        for (int g = 1; g <= 3; g++) begin
            sensor_b = 1'b1;
            repeat (g) @(negedge clk);
            sensor_b = 1'b0;
            repeat (8) @(negedge clk);
        end
        n_vec++; if (cnt_en != b_en || cnt_ex != b_ex || cnt_rj != b_rj) begin n_bad++; $display("FAIL backout_pulses got en=%0d ex=%0d rj=%0d want 0/0/0", cnt_en - b_en, cnt_ex - b_ex, cnt_rj - b_rj); end
        n_vec++; if (occupied !== 4'd1) begin n_bad++; $display("FAIL backout_occ got %0d want 1", occupied); end
        entry_passage();
        n_vec++; if (cnt_en - b_en != 1 || occupied !== 4'd2) begin n_bad++; $display("FAIL after_backout got en=%0d occ=%0d want 1/2", cnt_en - b_en, occupied); end
    endtask

    task automatic test_timeout();
        int b_en, b_rj, k_rj, exp_k, exp_n, occ0;
`ifdef GATE_TIMEOUT_EN
        exp_k = 2 + DEB + 1 + TO; exp_n = 1;
`else
        exp_k = 0; exp_n = 0;
`endif
        b_en = cnt_en; b_rj = cnt_rj; k_rj = 0; occ0 = occ_m;
        sensor_a = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (reject_pulse && k_rj == 0) k_rj = k;
        end
        n_vec++; if (k_rj != exp_k) begin n_bad++; $display("FAIL timeout_cycle got %0d want %0d", k_rj, exp_k); end
        sensor_a = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++; if (cnt_rj - b_rj != exp_n || cnt_en != b_en) begin n_bad++; $display("FAIL timeout_pulses got rj=%0d en=%0d want %0d/0", cnt_rj - b_rj, cnt_en - b_en, exp_n); end
        n_vec++; if (occupied !== 4'(occ0)) begin n_bad++; $display("FAIL timeout_occ got %0d want %0d", occupied, occ0); end
    endtask

    task automatic test_reset_midpassage();
        int b_en;
        do_reset();
        entry_passage();
        drive_level(2'b10, 10); drive_level(2'b11, 10);
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (occupied !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL async_reset_occ got %0d e=%b f=%b want 0/1/0", occupied, empty, full); end
        n_vec++; if (traffic_sign !== 3'b001 || entry_pulse !== 1'b0) begin n_bad++; $display("FAIL async_reset_sign got %b p=%b want 001/0", traffic_sign, entry_pulse); end
        sensor_a = 1'b0; sensor_b = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        b_en = cnt_en;
        entry_passage();
        n_vec++; if (cnt_en - b_en != 1 || occupied !== 4'd1) begin n_bad++; $display("FAIL reentry got en=%0d occ=%0d want 1/1", cnt_en - b_en, occupied); end
    endtask

    task automatic test_random();
        int b_en, b_ex, b_rj, e_en, e_ex, e_rj, dir, pos, steps, r;
        logic [1:0] nl;
        logic [2:0] want_sign;
        for (int p = 0; p < 25; p++) begin
            b_en = cnt_en; b_ex = cnt_ex; b_rj = cnt_rj;
            e_en = exp_en; e_ex = exp_ex; e_rj = exp_rj;
            dir = ($urandom_range(0, 1) == 0) ? 1 : -1;
            pos = 0;
            steps = $urandom_range(2, 7);
            for (int s = 0; s < steps; s++) begin
                r = $urandom_range(0, 7);
                if (r < 5) pos += dir; else if (r < 7) pos -= dir; else pos += 2;
                nl = lvl_of(pos);
                drive_level(nl, $urandom_range(8, 12));
                if (nl == 2'b00) break;
            end
            if (cur_l != 2'b00) drive_level(2'b00, 10);
            repeat (20) @(negedge clk);
            want_sign = (occ_m == CAP) ? 3'b100 : 3'b001;
            n_vec++; if (cnt_en - b_en != exp_en - e_en) begin n_bad++; $display("FAIL rnd%0d_entry got %0d want %0d", p, cnt_en - b_en, exp_en - e_en); end
            n_vec++; if (cnt_ex - b_ex != exp_ex - e_ex) begin n_bad++; $display("FAIL rnd%0d_exit got %0d want %0d", p, cnt_ex - b_ex, exp_ex - e_ex); end
            n_vec++; if (cnt_rj - b_rj != exp_rj - e_rj) begin n_bad++; $display("FAIL rnd%0d_reject got %0d want %0d", p, cnt_rj - b_rj, exp_rj - e_rj); end
            n_vec++; if (occupied !== 4'(occ_m) || full !== (occ_m == CAP) || empty !== (occ_m == 0)) begin n_bad++; $display("FAIL rnd%0d_occ got %0d f=%b e=%b want %0d", p, occupied, full, empty, occ_m); end
            n_vec++; if (traffic_sign !== want_sign) begin n_bad++; $display("FAIL rnd%0d_sign got %b want %b", p, traffic_sign, want_sign); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_clean_entry();
        test_fill_and_reject();
        test_exit_empty();
        test_backout_glitch();
        test_timeout();
        test_reset_midpassage();
        test_random();
        n_vec++; if (cnt_multi != 0) begin n_bad++; $display("FAIL pulse_exclusive got %0d overlapping cycles want 0", cnt_multi); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
